// File: rtl/pipe_rxdet_lfps_ctrl.sv
// MAC-side PIPE sequencer: far-end receiver detection and Polling.LFPS burst
// generation for the PHY low-speed control pins, all in the PHY clock domain.
module pipe_rxdet_lfps_ctrl #(
   parameter int unsigned PD_SETTLE      = 8,
   parameter int unsigned DETECT_TIMEOUT = 1024,
   parameter int unsigned BURST_CYCLES   = 250,
   parameter int unsigned REPEAT_CYCLES  = 2500
) (
   input  logic       clk_250mhz_i,
   input  logic       reset_i,
   input  logic       start_rxdet_i,
   input  logic       lfps_req_i,
   input  logic       phy_phy_status_2x_i,
   input  logic [2:0] phy_rx_status_2x_i,
   output logic [1:0] phy_power_down_o,
   output logic       phy_tx_detrx_lpbk_o,
   output logic       phy_tx_elecidle_o,
   output logic       busy_o,
   output logic       rxdet_done_o,
   output logic       rxdet_present_o,
   output logic       rxdet_timeout_o,
   output logic       lfps_active_o,
   output logic [7:0] lfps_bursts_o
);

   // state        | meaning
   // S_IDLE       | waiting for a detect or LFPS request
   // S_DET_SETTLE | settling in P2 before the detect request
   // S_DET_WAIT   | detect request high, waiting for PHY status or timeout
   // S_DET_DONE   | one-cycle result presentation
   // S_LFPS_ON    | electrical idle released, LFPS on the line (tBurst)
   // S_LFPS_OFF   | electrical idle asserted for the rest of tRepeat

   localparam int unsigned CNT_MAX = (REPEAT_CYCLES > DETECT_TIMEOUT) ? REPEAT_CYCLES
                                                                      : DETECT_TIMEOUT;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(PD_SETTLE - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(DETECT_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] BURST_LAST   = CNT_W'(BURST_CYCLES - 1);
   localparam logic [CNT_W-1:0] OFF_LAST     = CNT_W'(REPEAT_CYCLES - BURST_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DET_SETTLE,
      S_DET_WAIT,
      S_DET_DONE,
      S_LFPS_ON,
      S_LFPS_OFF
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_inc_d;
   logic [7:0]       bursts_q;
   logic [7:0]       bursts_inc_d;
   logic             present_d;
   logic [1:0]       pd_q;
   logic             detrx_q;
   logic             elecidle_q;
   logic             busy_q;
   logic             done_q;
   logic             present_q;
   logic             timeout_q;
   logic             active_q;

   assign cnt_inc_d    = cnt_q + 1'b1;
   assign bursts_inc_d = (bursts_q == 8'hFF) ? bursts_q : bursts_q + 8'd1;
   assign present_d    = (phy_rx_status_2x_i == 3'b011);

   always_ff @(posedge clk_250mhz_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bursts_q   <= '0;
         pd_q       <= 2'b10;
         detrx_q    <= 1'b0;
         elecidle_q <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         present_q  <= 1'b0;
         timeout_q  <= 1'b0;
         active_q   <= 1'b0;
      end else begin
         pd_q      <= 2'b10;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               cnt_q <= '0;
               // detect wins when both requests arrive together
               if (start_rxdet_i) begin
                  state_q <= S_DET_SETTLE;
                  busy_q  <= 1'b1;
               end else if (lfps_req_i) begin
                  state_q    <= S_LFPS_ON;
                  busy_q     <= 1'b1;
                  elecidle_q <= 1'b0;
                  active_q   <= 1'b1;
                  bursts_q   <= '0;
               end
            end
            S_DET_SETTLE: begin
               present_q <= 1'b0;
               if (cnt_q == SETTLE_LAST) begin
                  cnt_q   <= '0;
                  detrx_q <= 1'b1;
                  state_q <= S_DET_WAIT;
               end else begin
                  cnt_q <= cnt_inc_d;
               end
            end
            S_DET_WAIT: begin
               // a status strobe on the last timeout cycle still counts as an answer
               if (phy_phy_status_2x_i) begin
                  present_q <= present_d;
                  detrx_q   <= 1'b0;
                  done_q    <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= S_DET_DONE;
               end else if (cnt_q == TIMEOUT_LAST) begin
                  present_q <= 1'b0;
                  detrx_q   <= 1'b0;
                  done_q    <= 1'b1;
                  timeout_q <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= S_DET_DONE;
               end else begin
                  cnt_q <= cnt_inc_d;
               end
            end
            S_DET_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            S_LFPS_ON: begin
               if (cnt_q == BURST_LAST) begin
                  cnt_q      <= '0;
                  elecidle_q <= 1'b1;
                  active_q   <= 1'b0;
                  bursts_q   <= bursts_inc_d;
                  state_q    <= S_LFPS_OFF;
               end else begin
                  cnt_q <= cnt_inc_d;
               end
            end
            S_LFPS_OFF: begin
               // lfps_req is only looked at once a full tRepeat has elapsed
               if (cnt_q == OFF_LAST) begin
                  cnt_q <= '0;
                  if (lfps_req_i) begin
                     elecidle_q <= 1'b0;
                     active_q   <= 1'b1;
                     state_q    <= S_LFPS_ON;
                  end else begin
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end
               end else begin
                  cnt_q <= cnt_inc_d;
               end
            end
            default: begin
               state_q    <= S_IDLE;
               cnt_q      <= '0;
               detrx_q    <= 1'b0;
               elecidle_q <= 1'b1;
               active_q   <= 1'b0;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   assign phy_power_down_o    = pd_q;
   assign phy_tx_detrx_lpbk_o = detrx_q;
   assign phy_tx_elecidle_o   = elecidle_q;
   assign busy_o              = busy_q;
   assign rxdet_done_o        = done_q;
   assign rxdet_present_o     = present_q;
   assign rxdet_timeout_o     = timeout_q;
   assign lfps_active_o       = active_q;
   assign lfps_bursts_o       = bursts_q;

endmodule

// File: tb/tb_pipe_rxdet_lfps_ctrl.sv
// Scoreboard bench for pipe_rxdet_lfps_ctrl: stimulus pushes expected detect
// results and LFPS burst timings, a negedge monitor pops and compares them.
module tb_pipe_rxdet_lfps_ctrl;

   localparam int PD_SETTLE = 8;
   localparam int DET_TO    = 1024;
   localparam int BURST     = 250;
   localparam int REPEAT    = 2500;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start_rxdet = 1'b0;
   logic       lfps_req = 1'b0;
   logic       phy_status = 1'b0;
   logic [2:0] rx_status = 3'b000;
   logic [1:0] power_down;
   logic       detrx, elecidle, busy, done, present, timeout, active;
   logic [7:0] bursts;

   pipe_rxdet_lfps_ctrl #(
      .PD_SETTLE(PD_SETTLE), .DETECT_TIMEOUT(DET_TO),
      .BURST_CYCLES(BURST), .REPEAT_CYCLES(REPEAT)
   ) dut (
      .clk_250mhz_i(clk), .reset_i(reset), .start_rxdet_i(start_rxdet),
      .lfps_req_i(lfps_req), .phy_phy_status_2x_i(phy_status),
      .phy_rx_status_2x_i(rx_status), .phy_power_down_o(power_down),
      .phy_tx_detrx_lpbk_o(detrx), .phy_tx_elecidle_o(elecidle), .busy_o(busy),
      .rxdet_done_o(done), .rxdet_present_o(present), .rxdet_timeout_o(timeout),
      .lfps_active_o(active), .lfps_bursts_o(bursts)
   );

   always #2 clk = ~clk;

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   int checks = 0;
   int errors = 0;

   typedef struct { int rise; int done; bit present; bit timeout; } det_exp_t;
   typedef struct { int start; int len; int cnt_after; } lfps_exp_t;
   det_exp_t  det_q[$];
   lfps_exp_t lfps_q[$];

   function automatic void chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void fail_now(string name);
      checks++;
      errors++;
      $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
   endfunction

   // ---------------- monitor ----------------
   initial begin
      bit        prev_detrx = 1'b0;
      bit        prev_idle  = 1'b1;
      bit        prev_done  = 1'b0;
      int        rise_seen  = -1;
      bit        cur_valid  = 1'b0;
      lfps_exp_t cur;
      det_exp_t  e;
      forever begin
         @(negedge clk);
         chk("power_down_p2", int'(power_down), 2);
         if (detrx && !prev_detrx) begin
            rise_seen = cyc;
            chk("present_cleared_in_settle", int'(present), 0);
         end
         if (!elecidle && prev_idle) begin
            if (lfps_q.size() == 0) fail_now("unexpected_burst");
            else begin
               cur = lfps_q.pop_front();
               cur_valid = 1'b1;
               chk("burst_start_cycle", cyc, cur.start);
               chk("lfps_active_on", int'(active), 1);
            end
         end
         if (elecidle && !prev_idle && cur_valid) begin
            chk("burst_length", cyc - cur.start, cur.len);
            chk("lfps_bursts_after", int'(bursts), cur.cnt_after);
            chk("lfps_active_off", int'(active), 0);
            cur_valid = 1'b0;
         end
         if (done) begin
            if (det_q.size() == 0) fail_now("unexpected_rxdet_done");
            else begin
               e = det_q.pop_front();
               chk("done_cycle", cyc, e.done);
               chk("detrx_rise_cycle", rise_seen, e.rise);
               chk("rxdet_present", int'(present), int'(e.present));
               chk("rxdet_timeout", int'(timeout), int'(e.timeout));
               chk("detrx_low_in_done", int'(detrx), 0);
            end
         end else if (timeout) fail_now("timeout_without_done");
         if (prev_done) begin
            chk("done_one_cycle", int'(done), 0);
            chk("busy_low_after_done", int'(busy), 0);
         end
         prev_detrx = detrx;
         prev_idle  = elecidle;
         prev_done  = done;
      end
   end

   initial begin
      #(4 * 200000);
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference model / stimulus ----------------
   task automatic step(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Bursts start every REPEAT cycles from s0; burst k>0 exists only if the
   // request was still high on the edge that would start it (edge <= r).
   function automatic int lfps_expect(int s0, int r);
      int        n = 0;
      lfps_exp_t b;
      do begin
         b.start     = s0 + n * REPEAT;
         b.len       = BURST;
         b.cnt_after = (n + 1 > 255) ? 255 : n + 1;
         lfps_q.push_back(b);
         n++;
      end while (s0 + n * REPEAT <= r);
      return n;
   endfunction

   // d < 0: PHY silent. Otherwise status arrives d cycles after detrx rises.
   function automatic det_exp_t det_expect(int n, int d, logic [2:0] rv);
      det_exp_t e;
      bit       to;
      to        = (d < 0) || (d >= DET_TO);
      e.rise    = n + 1 + PD_SETTLE;
      e.done    = n + 2 + PD_SETTLE + (to ? DET_TO - 1 : d);
      e.timeout = to;
      e.present = !to && (rv == 3'b011);
      return e;
   endfunction

   task automatic phy_answer(int d, logic [2:0] rv);
      step(PD_SETTLE + d);
      phy_status = 1'b1;
      rx_status  = rv;
      step(1);
      phy_status = 1'b0;
      rx_status  = 3'($urandom_range(7, 0));
   endtask

   task automatic run_detect(int d, logic [2:0] rv);
      int       n;
      int       t_end;
      det_exp_t e;
      n = cyc;
      e = det_expect(n, d, rv);
      det_q.push_back(e);
      start_rxdet = 1'b1;
      step(1);
      start_rxdet = 1'b0;
      t_end = e.done;
      if (d >= 0) begin
         phy_answer(d, rv);
         if (n + 2 + PD_SETTLE + d > t_end) t_end = n + 2 + PD_SETTLE + d;
      end
      step(t_end + 2 - cyc);
   endtask

   task automatic run_lfps(int hold);
      int n, s0, nb;
      n  = cyc;
      s0 = n + 1;
      nb = lfps_expect(s0, n + hold);
      lfps_req = 1'b1;
      step(hold / 2);
      start_rxdet = 1'b1;
      step(1);
      start_rxdet = 1'b0;
      step(hold - hold / 2 - 1);
      lfps_req = 1'b0;
      step(s0 + nb * REPEAT + 2 - cyc);
      chk("lfps_busy_end", int'(busy), 0);
      chk("lfps_bursts_end", int'(bursts), nb);
      chk("elecidle_end", int'(elecidle), 1);
   endtask

   initial begin
      int       n, d, s0, nb, x;
      det_exp_t e;

      // reset held three cycles
      step(3);
      chk("rst_power_down", int'(power_down), 2);
      chk("rst_elecidle", int'(elecidle), 1);
      chk("rst_detrx", int'(detrx), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_bursts", int'(bursts), 0);
      reset = 1'b0;
      step(2);
      chk("idle_busy", int'(busy), 0);
      chk("idle_done", int'(done), 0);
      chk("idle_present", int'(present), 0);

      // directed detect cases, including timeout boundary
      run_detect(20, 3'b011);
      run_detect(-1, 3'b000);
      run_detect(15, 3'b000);
      run_detect(DET_TO - 1, 3'b000);
      run_detect(DET_TO - 1, 3'b011);
      run_detect(DET_TO, 3'b011);
      run_detect(0, 3'b011);

      for (int i = 0; i < 6; i++) begin
         d = int'($urandom_range(60, 0));
         run_detect(d, ($urandom_range(1, 0) == 1) ? 3'b011 : 3'($urandom_range(7, 0)));
      end

      // three bursts, request dropped part-way through the third
      run_lfps(1 + 2 * REPEAT + int'($urandom_range(BURST - 2, 0)));
      run_lfps(int'($urandom_range(2 * REPEAT, 2)));

      // detect and LFPS requested together: detect first, LFPS after DET_DONE
      n = cyc;
      d = int'($urandom_range(40, 0));
      e = det_expect(n, d, 3'b011);
      det_q.push_back(e);
      s0 = e.done + 2;
      nb = lfps_expect(s0, s0 + REPEAT + int'($urandom_range(2000, 0)));
      start_rxdet = 1'b1;
      lfps_req    = 1'b1;
      step(1);
      start_rxdet = 1'b0;
      phy_answer(d, 3'b011);
      step(s0 + REPEAT - cyc);
      step(int'($urandom_range(2000, 0)));
      lfps_req = 1'b0;
      step(s0 + nb * REPEAT + 2 - cyc);
      chk("combo_busy_end", int'(busy), 0);
      chk("combo_bursts_end", int'(bursts), nb);

      // reset during LFPS_ON
      n  = cyc;
      s0 = n + 1;
      x  = int'($urandom_range(200, 10));
      begin
         lfps_exp_t b;
         b.start = s0; b.len = x + 1; b.cnt_after = 0;
         lfps_q.push_back(b);
      end
      lfps_req = 1'b1;
      step(1 + x);
      reset    = 1'b1;
      lfps_req = 1'b0;
      step(1);
      chk("reset_elecidle", int'(elecidle), 1);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      step(2);
      reset = 1'b0;
      step(REPEAT + 500);
      chk("post_reset_bursts", int'(bursts), 0);
      chk("post_reset_busy", int'(busy), 0);

      chk("det_queue_empty", det_q.size(), 0);
      chk("lfps_queue_empty", lfps_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_rxdet_lfps_ctrl.md
Name: pipe_rxdet_lfps_ctrl

Overview:
MAC-side PIPE 3.0 sequencer that drives the low-speed control side of the internal ECP5 PHY wrapper.
- Initiates far-end receiver detection: P2 entry, phy_tx_detrx_lpbk, then waits for phy_phy_status_2x / phy_rx_status_2x.
- Generates Polling.LFPS bursts by toggling phy_tx_elecidle while in P2, which the PHY turns into LFPS on the line.
- Sits between the LTSSM and the PHY pipe control ports, in the clk_250mhz domain.

Parameters:
PD_SETTLE, 8, cycles held in P2 before asserting phy_tx_detrx_lpbk (min 1)
DETECT_TIMEOUT, 1024, cycles to wait for phy_phy_status_2x before aborting detect
BURST_CYCLES, 250, LFPS tBurst in clocks (1 us at 250 MHz); min 1
REPEAT_CYCLES, 2500, LFPS tRepeat in clocks (10 us); must exceed BURST_CYCLES

Ports:
clk_250mhz  in  1  PHY-domain clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
start_rxdet  in  1  single-cycle request to run receiver detection
lfps_req  in  1  level; request repeated Polling.LFPS bursts
phy_phy_status_2x  in  1  PHY completion strobe
phy_rx_status_2x  in  3  PHY status; 3'b011 = receiver present, sampled only with phy_phy_status_2x
phy_power_down  out  2  PIPE power state
phy_tx_detrx_lpbk  out  1  receiver-detect request to the PHY
phy_tx_elecidle  out  1  TX electrical idle; low in P2 = LFPS on the line
busy  out  1  high in any non-IDLE state
rxdet_done  out  1  one-cycle pulse when detection finishes
rxdet_present  out  1  result; valid while rxdet_done is high, holds until the next detect starts
rxdet_timeout  out  1  one-cycle pulse, coincident with rxdet_done, on timeout
lfps_active  out  1  high while in LFPS_ON
lfps_bursts  out  8  saturating count of completed bursts; cleared on LFPS entry

Behaviour:
- All outputs are registered.
- Reset values: phy_power_down=2'b10, phy_tx_elecidle=1, phy_tx_detrx_lpbk=0, busy=0, rxdet_done=0, rxdet_present=0, rxdet_timeout=0, lfps_active=0, lfps_bursts=0, state=IDLE, counters=0.
- Reset asserted mid-operation returns everything to the reset values on that edge, with no done pulse. The next edge after reset deasserts is IDLE.
- phy_power_down is held at 2'b10 (P2) in every state. This block never leaves P2.
- States: IDLE, DET_SETTLE, DET_WAIT, DET_DONE, LFPS_ON, LFPS_OFF.
- IDLE:
  - start_rxdet=1 -> DET_SETTLE. This has priority over lfps_req when both are high in the same cycle.
  - Otherwise lfps_req=1 -> LFPS_ON, with lfps_bursts cleared.
  - Requests arriving in any other state are ignored; start_rxdet is not queued.
- DET_SETTLE:
  - Clears rxdet_present.
  - Counts PD_SETTLE cycles, then -> DET_WAIT.
  - phy_tx_detrx_lpbk rises on the first DET_WAIT cycle.
- DET_WAIT:
  - Holds phy_tx_detrx_lpbk=1 and a timer starting at 0.
  - On a cycle with phy_phy_status_2x=1: capture rxdet_present = (phy_rx_status_2x==3'b011), then -> DET_DONE.
  - Else, if the timer reaches DETECT_TIMEOUT-1: rxdet_present=0, flag timeout, -> DET_DONE.
  - If status and timeout land on the same cycle, status wins and there is no timeout pulse.
- DET_DONE:
  - Lasts one cycle: phy_tx_detrx_lpbk=0, rxdet_done=1, rxdet_timeout=flag.
  - Then -> IDLE.
- LFPS_ON:
  - phy_tx_elecidle=0 and lfps_active=1 for exactly BURST_CYCLES cycles.
  - Then -> LFPS_OFF, and lfps_bursts increments, saturating at 255.
- LFPS_OFF:
  - phy_tx_elecidle=1 for REPEAT_CYCLES-BURST_CYCLES cycles.
  - At the end: lfps_req=1 -> LFPS_ON; else -> IDLE.
- lfps_req deassertion is only observed at the end of LFPS_OFF. A burst in progress always completes its full tRepeat.
- Counter width is $clog2(max(REPEAT_CYCLES, DETECT_TIMEOUT)+1). A single shared counter is allowed.

Test Plan:
1. Reset held 3 cycles, then released -> power_down=10, elecidle=1, detrx=0, busy=0, lfps_bursts=0.
2. start_rxdet pulse at cycle T; PHY returns status=1 with rx_status=011, 20 cycles after detrx rises -> detrx high from T+1+8 until DET_DONE; rxdet_done=1 with rxdet_present=1, rxdet_timeout=0; busy low the cycle after.
3. start_rxdet with the PHY silent -> detrx held exactly 1024 cycles; rxdet_done=1 with rxdet_present=0 and rxdet_timeout=1 on the same cycle.
4. Status with rx_status=000, and a separate run with status on the final timeout cycle -> rxdet_present=0 and timeout=0 in both runs.
5. lfps_req held high for 3 bursts, then dropped mid-burst 3 -> elecidle low for exactly 250 cycles at each burst start, bursts spaced 2500 cycles apart; IDLE after the 3rd LFPS_OFF ends; lfps_bursts=3.
6. start_rxdet and lfps_req rise together in IDLE -> detect runs first; LFPS starts after DET_DONE if lfps_req is still high. A separate run asserts reset mid-LFPS_ON -> elecidle=1 on the next edge and no further bursts.
